// File: rtl/ochiba_frame_sched_if.sv
// ochiba_frame_sched_if: core frame load/store bus into the RAM scheduler
interface ochiba_frame_sched_if #(
  parameter int FRAME_W = 1048,
  parameter int ADDR_W  = 16
) ();
  logic               core_req;
  logic               core_we;
  logic [ADDR_W-1:0]  core_addr;
  logic [FRAME_W-1:0] core_wdata;
  logic [FRAME_W-1:0] core_rdata;
  logic               core_stall;
  modport master (output core_req, core_we, core_addr, core_wdata, input core_rdata, core_stall);
  modport slave  (input core_req, core_we, core_addr, core_wdata, output core_rdata, core_stall);
endinterface

// File: rtl/ochiba_frame_sched.sv
// ochiba_frame_sched: shares the frame RAM between the core and an RX-ring / TX Ethernet engine
module ochiba_frame_sched #(
  parameter int                FRAME_W = 1048,
  parameter int                ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] RX_BASE = 'h8000,
  parameter int                SLOTS   = 4,
  parameter int                STARVE  = 4,
  localparam int               PW      = $clog2(SLOTS),
  localparam int               CW      = PW + 1,
  localparam int               SW      = $clog2(STARVE + 1)
) (
  input  logic               clk,
  input  logic               reset,
  ochiba_frame_sched_if.slave core,
  input  logic               rxfifoemp,
  output logic               ethernet_rx_re,
  input  logic [FRAME_W-1:0] ethernet_rx,
  output logic [FRAME_W-1:0] ethernet_tx,
  output logic               ethernet_tx_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [FRAME_W-1:0] ram_wdata,
  output logic               ram_we,
  input  logic [FRAME_W-1:0] ram_rdata,
  input  logic               tx_start,
  input  logic [ADDR_W-1:0]  tx_addr,
  output logic               tx_busy,
  input  logic               rx_pop,
  output logic [ADDR_W-1:0]  rx_head,
  output logic [CW-1:0]      rx_count
);
  typedef enum logic [2:0] {IDLE, RX_RD, RX_WR, TX_RD, TX_WT, TX_SEND} state_t;
  state_t             state_q, state_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [SW-1:0]      starve_q, starve_d;
  logic               tx_busy_q, tx_busy_d;
  logic [ADDR_W-1:0]  tx_addr_q, tx_addr_d;
  logic [FRAME_W-1:0] ethernet_tx_q, ethernet_tx_d;
  logic               rx_ok, eng_req, eng_win, pop_ok;
  assign rx_ok           = !rxfifoemp && count_q < CW'(SLOTS);
  assign eng_req         = tx_busy_q || rx_ok;
  assign eng_win         = eng_req && (!core.core_req || starve_q == SW'(STARVE));
  assign pop_ok          = rx_pop && count_q != '0;
  assign core.core_rdata = ram_rdata;
  assign ethernet_tx     = ethernet_tx_q;
  assign tx_busy         = tx_busy_q;
  assign rx_count        = count_q;
  assign rx_head         = RX_BASE + ADDR_W'(rd_ptr_q);
  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    starve_d        = starve_q;
    tx_busy_d       = tx_busy_q;
    tx_addr_d       = tx_addr_q;
    ethernet_tx_d   = ethernet_tx_q;
    ethernet_rx_re  = 1'b0;
    ethernet_tx_we  = 1'b0;
    ram_we          = 1'b0;
    ram_addr        = core.core_addr;
    ram_wdata       = core.core_wdata;
    core.core_stall = core.core_req;
    if (tx_start && !tx_busy_q) begin
      tx_busy_d = 1'b1;
      tx_addr_d = tx_addr;
    end
    case (state_q)
      IDLE: begin
        state_d         = eng_win ? (tx_busy_q ? TX_RD : RX_RD) : IDLE;
        starve_d        = (eng_win || !eng_req) ? '0 : starve_q + SW'(1);
        core.core_stall = core.core_req && eng_win;
        ram_we          = core.core_req && core.core_we && !eng_win;
      end
      RX_RD: begin
        ethernet_rx_re = 1'b1;
        state_d        = RX_WR;
      end
      RX_WR: begin
        ram_we    = 1'b1;
        ram_addr  = RX_BASE + ADDR_W'(wr_ptr_q);
        ram_wdata = ethernet_rx;
        wr_ptr_d  = wr_ptr_q + PW'(1);
        state_d   = IDLE;
      end
      TX_RD: begin
        ram_addr = tx_addr_q;
        state_d  = TX_WT;
      end
      TX_WT: begin
        ethernet_tx_d = ram_rdata;
        state_d       = TX_SEND;
      end
      TX_SEND: begin
        ethernet_tx_we = 1'b1;
        tx_busy_d      = 1'b0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + CW'(state_q == RX_WR) - CW'(pop_ok);
    // reset aborts any sequence, so nothing may reach the RAM or the FIFOs in that cycle
    if (reset) begin
      ethernet_rx_re  = 1'b0;
      ethernet_tx_we  = 1'b0;
      ram_we          = 1'b0;
      core.core_stall = core.core_req;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      starve_q      <= '0;
      tx_busy_q     <= 1'b0;
      tx_addr_q     <= '0;
      ethernet_tx_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      starve_q      <= starve_d;
      tx_busy_q     <= tx_busy_d;
      tx_addr_q     <= tx_addr_d;
      ethernet_tx_q <= ethernet_tx_d;
    end
  end
endmodule
